// File: rtl/sm_twos_convert_stream.sv
// sm_twos_convert_stream: multi-lane pipelined sign-magnitude <-> two's
// complement converter with valid/ready handshake on both sides.
//
// Parameters:
//   W      word width including sign bit (>= 3)
//   LANES  words per beat (>= 1)
//   PIPE   register stages from input to output (1..4)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_mode    0: SM->2C, 1: 2C->SM, travels with its beat
//   in_data    LANES packed words, lane i at [i*W +: W]
//   out_valid  output beat valid
//   out_ready  downstream accepts
//   out_data   converted words, same packing
//   out_negz   per lane: SM input was negative zero (mode 0)
//   out_sat    per lane: 2C input was -2^(W-1), saturated (mode 1)
//
// Optional build macro SM_TWOS_CONVERT_STATS_EN adds two saturating
// 32-bit counters, stat_negz_cnt and stat_sat_cnt, that accumulate the
// popcount of out_negz / out_sat on every accepted output beat.

module sm_twos_convert_stream #(
    parameter int W     = 9,
    parameter int LANES = 4,
    parameter int PIPE  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [LANES*W-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic [LANES-1:0]     out_negz,
    output logic [LANES-1:0]     out_sat
`ifdef SM_TWOS_CONVERT_STATS_EN
    ,
    output logic [31:0]          stat_negz_cnt,
    output logic [31:0]          stat_sat_cnt
`endif
);

    localparam logic [W-1:0] ONE = W'(1);

    // Returns {sat, negz, word} for one lane.
    function automatic logic [W+1:0] conv_lane(
        input logic         mode,
        input logic [W-1:0] word
    );
        logic         sign;
        logic [W-2:0] mag;
        logic [W-1:0] pos;
        logic [W-1:0] res;
        logic         nz;
        logic         st;
        sign = word[W-1];
        mag  = word[W-2:0];
        pos  = {1'b0, mag};
        res  = word;
        nz   = 1'b0;
        st   = 1'b0;
        if (!mode) begin
            if (sign) begin
                if (mag == '0) begin
                    // -0 collapses to +0 so we never emit -2^(W-1)
                    res = '0;
                    nz  = 1'b1;
                end else begin
                    res = ~pos + ONE;
                end
            end
        end else begin
            if (sign) begin
                if (mag == '0) begin
                    // -2^(W-1) has no SM encoding; clamp to -(2^(W-1)-1)
                    res = '1;
                    st  = 1'b1;
                end else begin
                    res = ~word + ONE;
                    res = {1'b1, res[W-2:0]};
                end
            end
        end
        return {st, nz, res};
    endfunction

    logic [LANES*W-1:0] conv_data;
    logic [LANES-1:0]   conv_negz;
    logic [LANES-1:0]   conv_sat;

    always_comb begin
        logic [W+1:0] r;
        conv_data = '0;
        conv_negz = '0;
        conv_sat  = '0;
        r         = '0;
        for (int l = 0; l < LANES; l++) begin
            r = conv_lane(in_mode, in_data[l*W +: W]);
            conv_data[l*W +: W] = r[W-1:0];
            conv_negz[l]        = r[W];
            conv_sat[l]         = r[W+1];
        end
    end

    logic [PIPE-1:0]    valid_q;
    logic [LANES*W-1:0] data_q [PIPE];
    logic [LANES-1:0]   negz_q [PIPE];
    logic [LANES-1:0]   sat_q  [PIPE];

    logic [PIPE-1:0]    valid_d;
    logic [LANES*W-1:0] data_d [PIPE];
    logic [LANES-1:0]   negz_d [PIPE];
    logic [LANES-1:0]   sat_d  [PIPE];

    logic [PIPE-1:0]    load;

    // A stage may load when the output drains or any stage at or
    // downstream of it is empty; this lets bubbles collapse.
    always_comb begin
        logic hole;
        hole = 1'b0;
        load = '0;
        for (int k = PIPE - 1; k >= 0; k--) begin
            hole    = hole | ~valid_q[k];
            load[k] = out_ready | hole;
        end
    end

    // Stage 1 takes the converted input; later stages shift.
    always_comb begin
        valid_d    = '0;
        data_d     = '{default: '0};
        negz_d     = '{default: '0};
        sat_d      = '{default: '0};
        valid_d[0] = in_valid;
        data_d[0]  = conv_data;
        negz_d[0]  = conv_negz & {LANES{~in_mode}};
        sat_d[0]   = conv_sat & {LANES{in_mode}};
        for (int k = 1; k < PIPE; k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
            negz_d[k]  = negz_q[k-1];
            sat_d[k]   = sat_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                data_q[k] <= '0;
                negz_q[k] <= '0;
                sat_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_d[k];
                    // Bubbles leave the payload untouched
                    if (valid_d[k]) begin
                        data_q[k] <= data_d[k];
                        negz_q[k] <= negz_d[k];
                        sat_q[k]  <= sat_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[PIPE-1];
    assign out_data  = data_q[PIPE-1];
    assign out_negz  = negz_q[PIPE-1];
    assign out_sat   = sat_q[PIPE-1];

`ifdef SM_TWOS_CONVERT_STATS_EN
    function automatic logic [31:0] sat_add(
        input logic [31:0]      acc,
        input logic [LANES-1:0] bits
    );
        logic [32:0] s;
        s = {1'b0, acc};
        for (int i = 0; i < LANES; i++) begin
            s = s + 33'(bits[i]);
        end
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [31:0] negz_cnt_q, negz_cnt_d;
    logic [31:0] sat_cnt_q, sat_cnt_d;
    logic        fire;

    assign fire = out_valid & out_ready;

    always_comb begin
        negz_cnt_d = negz_cnt_q;
        sat_cnt_d  = sat_cnt_q;
        if (fire) begin
            negz_cnt_d = sat_add(negz_cnt_q, out_negz);
            sat_cnt_d  = sat_add(sat_cnt_q, out_sat);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            negz_cnt_q <= '0;
            sat_cnt_q  <= '0;
        end else begin
            negz_cnt_q <= negz_cnt_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign stat_negz_cnt = negz_cnt_q;
    assign stat_sat_cnt  = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sm_twos_convert_stream.sv
// tb_sm_twos_convert_stream: directed bench for sm_twos_convert_stream
// (W=9, LANES=4, PIPE=2) with hand-computed expected beats.

module tb_sm_twos_convert_stream;

    localparam int W     = 9;
    localparam int LANES = 4;
    localparam int PIPE  = 2;
    localparam int NV    = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [LANES*W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LANES*W-1:0] out_data;
    logic [LANES-1:0]  out_negz;
    logic [LANES-1:0]  out_sat;
`ifdef SM_TWOS_CONVERT_STATS_EN
    logic [31:0]       stat_negz_cnt;
    logic [31:0]       stat_sat_cnt;
`endif

    sm_twos_convert_stream #(
        .W(W), .LANES(LANES), .PIPE(PIPE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_negz  (out_negz),
`ifdef SM_TWOS_CONVERT_STATS_EN
        .out_sat   (out_sat),
        .stat_negz_cnt (stat_negz_cnt),
        .stat_sat_cnt  (stat_sat_cnt)
`else
        .out_sat   (out_sat)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [35:0] vin  [NV];
    logic [35:0] vexp [NV];
    logic        vmode[NV];
    logic [3:0]  vnz  [NV];
    logic [3:0]  vst  [NV];

    task automatic set_vec(input int i, input logic m, input logic [35:0] d,
                           input logic [35:0] e, input logic [3:0] nz,
                           input logic [3:0] st);
        vmode[i] = m;
        vin[i]   = d;
        vexp[i]  = e;
        vnz[i]   = nz;
        vst[i]   = st;
    endtask

    task automatic drive(input int i);
        in_valid = 1'b1;
        in_mode  = vmode[i];
        in_data  = vin[i];
    endtask

    task automatic chk_out(input string tag, input int i);
        chk({tag, "_data"}, out_data, vexp[i]);
        chk({tag, "_negz"}, out_negz, vnz[i]);
        chk({tag, "_sat"},  out_sat,  vst[i]);
    endtask

    // Entered and left just after a rising edge.
    task automatic run_one(input string tag, input int i);
        drive(i);
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_lat2"}, out_valid, 1);
        chk_out(tag, i);
        @(negedge clk);
        chk({tag, "_gone"}, out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int sent, got, cnt, acc, del;
        logic exp_rdy;

        set_vec(0, 1'b0, {9'h100, 9'h1FF, 9'h080, 9'h001},
                {9'h000, 9'h101, 9'h080, 9'h001}, 4'b1000, 4'b0000);
        set_vec(1, 1'b1, {9'h100, 9'h1FF, 9'h080, 9'h001},
                {9'h1FF, 9'h101, 9'h080, 9'h001}, 4'b0000, 4'b1000);
        set_vec(2, 1'b0, {9'h0AA, 9'h155, 9'h1C0, 9'h17F},
                {9'h0AA, 9'h1AB, 9'h140, 9'h181}, 4'b0000, 4'b0000);
        set_vec(3, 1'b1, {9'h1FE, 9'h000, 9'h100, 9'h100},
                {9'h102, 9'h000, 9'h1FF, 9'h1FF}, 4'b0000, 4'b0011);
        set_vec(4, 1'b0, {9'h1FE, 9'h000, 9'h100, 9'h100},
                {9'h102, 9'h000, 9'h000, 9'h000}, 4'b0011, 4'b0000);
        set_vec(5, 1'b1, {9'h0AA, 9'h155, 9'h1C0, 9'h17F},
                {9'h0AA, 9'h1AB, 9'h140, 9'h181}, 4'b0000, 4'b0000);
        set_vec(6, 1'b0, {9'h000, 9'h1FF, 9'h105, 9'h005},
                {9'h000, 9'h101, 9'h1FB, 9'h005}, 4'b0000, 4'b0000);
        set_vec(7, 1'b0, {9'h0FF, 9'h100, 9'h005, 9'h100},
                {9'h0FF, 9'h000, 9'h005, 9'h000}, 4'b0101, 4'b0000);
        set_vec(8, 1'b1, {9'h101, 9'h0FF, 9'h100, 9'h1FB},
                {9'h1FF, 9'h0FF, 9'h1FF, 9'h105}, 4'b0000, 4'b0010);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_negz",  out_negz,  0);
        chk("rst_sat",   out_sat,   0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", in_ready, 1);
        @(posedge clk); #1;

        run_one("t1", 6);
        run_one("negz", 7);
        run_one("m1", 8);

        // Alternating modes at full rate, out_ready held high
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 6) drive(c);
            else in_valid = 1'b0;
            @(negedge clk);
            if (c < 6) chk("alt_rdy", in_ready, 1);
            if (c >= 2) begin
                chk("alt_valid", out_valid, 1);
                chk_out("alt", c - 2);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("alt_drain", out_valid, 0);
        @(posedge clk); #1;

`ifdef SM_TWOS_CONVERT_STATS_EN
        chk("stat_negz", stat_negz_cnt, 5);
        chk("stat_sat",  stat_sat_cnt,  4);
`endif

        // Random back-pressure, 10 beats; occupancy model predicts in_ready
        sent = 0;
        got  = 0;
        cnt  = 0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            if (sent < 10 && $urandom_range(0, 3) != 0) drive(sent % NV);
            else in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_rdy = !(cnt == PIPE && !out_ready);
            chk("bp_rdy", in_ready, exp_rdy);
            chk("bp_spur", out_valid && cnt == 0, 0);
            if (out_valid) chk_out("bp", got % NV);
            acc = (in_valid && exp_rdy) ? 1 : 0;
            del = (out_valid && out_ready) ? 1 : 0;
            @(posedge clk); #1;
            sent += acc;
            got  += del;
            cnt  += acc - del;
        end
        chk("bp_count", got, 10);
        in_valid = 1'b0;

        // Fill and stall the pipe, then reset
        out_ready = 1'b0;
        drive(0);
        @(posedge clk); #1;
        drive(1);
        @(posedge clk); #1;
        drive(2);
        @(negedge clk);
        chk("stall_rdy", in_ready, 0);
        chk("stall_valid", out_valid, 1);
        chk_out("stall", 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk_out("hold", 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("srst_valid", out_valid, 0);
        chk("srst_data",  out_data,  0);
        chk("srst_negz",  out_negz,  0);
        chk("srst_sat",   out_sat,   0);
        chk("srst_rdy",   in_ready,  1);
`ifdef SM_TWOS_CONVERT_STATS_EN
        chk("srst_snegz", stat_negz_cnt, 0);
        chk("srst_ssat",  stat_sat_cnt,  0);
`endif
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("srst_empty", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm_twos_convert_stream.md
Name: sm_twos_convert_stream

Overview:
- Multi-lane, pipelined, bidirectional converter between sign-magnitude and two's complement.
- Sits between the INT8 OS processing array and the operand/result buffers.
- Converts LANES packed W-bit words per beat under a valid/ready handshake.
- Run-time mode selects direction per beat.
- Negative zero and the unrepresentable most-negative value are handled explicitly and flagged.

Parameters:
- W, 9, total word width including sign bit (>= 3).
- LANES, 4, words per beat (>= 1).
- PIPE, 2, register stages from input to output (1..4).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_mode  in  1  0: SM->2C, 1: 2C->SM; sampled with the beat.
- in_data  in  LANES*W  packed words, lane i at [i*W +: W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*W  converted words, same lane packing.
- out_negz  out  LANES  per-lane: SM input was negative zero (mode 0 only).
- out_sat  out  LANES  per-lane: 2C input was -2^(W-1) and was saturated (mode 1 only).

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valid bits clear.
  - out_valid=0, out_data=0, out_negz=0, out_sat=0.
  - Beats in flight are discarded; no partial beat survives.
  - in_ready=1 from the first cycle after reset deasserts.
- Pipeline structure:
  - PIPE stages, each holding valid, data, negz and sat.
  - Conversion is combinational in front of stage 1; later stages are pure delay.
  - Stage k loads when it is empty or stage k+1 (or the output for the last stage) accepts this cycle.
  - in_ready = stage-1 load condition, combinational from out_ready.
- Timing:
  - Latency is exactly PIPE cycles with no back-pressure.
  - Throughput is 1 beat per cycle.
  - No bubbles are inserted when out_ready stays 1.
- Back-pressure: while out_valid=1 and out_ready=0, out_data, out_negz and out_sat hold stable. Bubbles in upstream stages collapse, so the pipe can fill completely.
- Ordering: beats leave in acceptance order. Mode travels with its beat, so mixed-mode streams are legal back-to-back.
- SM->2C (mode 0), per lane, with s = MSB and m = low W-1 bits:
  - s=0: output = input.
  - s=1, m!=0: output = two's complement of -m in W bits (MSB=1).
  - s=1, m=0: output = 0 and negz=1. Never produce -2^(W-1).
- 2C->SM (mode 1), per lane, with x signed:
  - x>=0: output = x.
  - x<0 and x != -2^(W-1): output = {1, |x| in W-1 bits}.
  - x = -2^(W-1): output = {1, all ones}, i.e. -(2^(W-1)-1), and sat=1.
- Flag gating: negz is forced to 0 in mode 1; sat is forced to 0 in mode 0.
- Reset during a stall: the beat is dropped and out_valid=0 on the next cycle.

Optional Feature:
- Macro: SM_TWOS_CONVERT_STATS_EN.
- With the macro defined:
  - Adds outputs stat_negz_cnt (out, 32) and stat_sat_cnt (out, 32).
  - Each counter increments on every out_valid && out_ready beat by the popcount of out_negz or out_sat respectively.
  - Counters saturate at 2^32-1 and clear on rst.
- Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan (W=9, LANES=4, PIPE=2 unless noted):
- Mode 0, lanes {0x005,0x105,0x1FF,0x000}, out_ready=1:
  - Beat appears exactly 2 cycles after acceptance with {0x005,0x1FB,0x101,0x000}.
  - negz=0, sat=0.
- Mode 0, lane 0x100 (negative zero): output 0x000, negz[lane]=1. The output must not be 0x100.
- Mode 1, lanes {0x1FB,0x100,0x0FF,0x101}:
  - Output {0x105,0x1FF,0x0FF,0x1FF}.
  - sat={0,1,0,0}.
- Back-pressure, 10 random beats with out_ready toggling randomly:
  - No loss, duplication or reordering.
  - Output holds while stalled.
  - in_ready=0 only when both stages are full and out_ready=0.
- Alternating mode per beat at full rate: each beat converted per its own mode, throughput 1/cycle.
- Assert rst with a full, stalled pipe:
  - Next cycle out_valid=0 and outputs are 0.
  - With the stats macro defined, both counters read 0.
